// File: rtl/seg_scan_controller.sv
// Multiplexed 7-segment scan controller: numeric, "OPEN"/"CLOSE" text and raw-segment modes.
// Optional whole-display blinking is built only when SEG_BLINK_EN is defined.
module seg_scan_controller #(
  parameter int DIGITS       = 6,
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [3:0]            digit_count,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [8*DIGITS-1:0]   raw_seg,
  input  logic                  blink_en,
  output logic [7:0]            seg_data,
  output logic [DIGITS-1:0]     seg_pos,
  output logic                  scan_tick,
  output logic                  frame_start
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]     presc;
  logic [AW-1:0]     ptr;
  logic [AW-1:0]     ptr_next;
  logic              tick_now;
  logic [3:0]        nib;
  logic [7:0]        raw;
  logic              dp;
  logic              shown;
  logic [7:0]        data_next;
  logic [DIGITS-1:0] pos_next;
  logic              blank;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_seg = 8'hFC;
      4'h1: hex_seg = 8'h60;
      4'h2: hex_seg = 8'hDA;
      4'h3: hex_seg = 8'hF2;
      4'h4: hex_seg = 8'h66;
      4'h5: hex_seg = 8'hB6;
      4'h6: hex_seg = 8'hBE;
      4'h7: hex_seg = 8'hE0;
      4'h8: hex_seg = 8'hFE;
      4'h9: hex_seg = 8'hF6;
      4'hA: hex_seg = 8'hEE;
      4'hB: hex_seg = 8'h3E;
      4'hC: hex_seg = 8'h9C;
      4'hD: hex_seg = 8'h7A;
      4'hE: hex_seg = 8'h9E;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  // Characters past the last digit never get selected, so text truncates naturally.
  function automatic logic [7:0] open_seg(input logic [AW-1:0] p);
    case (int'(p))
      0: open_seg = 8'hFC;
      1: open_seg = 8'hCE;
      2: open_seg = 8'h9E;
      3: open_seg = 8'hEC;
      default: open_seg = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] close_seg(input logic [AW-1:0] p);
    case (int'(p))
      0: close_seg = 8'h9C;
      1: close_seg = 8'h1C;
      2: close_seg = 8'hFC;
      3: close_seg = 8'hB6;
      4: close_seg = 8'h9E;
      default: close_seg = 8'h00;
    endcase
  endfunction

  assign tick_now = (presc == PW'(CLK_DIV - 1));
  assign ptr_next = (ptr == AW'(DIGITS - 1)) ? '0 : ptr + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick_now) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Everything below is computed for the digit the pointer moves to on this tick.
  always_comb begin
    nib      = '0;
    raw      = '0;
    dp       = 1'b0;
    pos_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ptr_next == AW'(i)) begin
        nib                  = digit_data[4*i +: 4];
        raw                  = raw_seg[8*i +: 8];
        dp                   = dp_mask[i];
        pos_next[DIGITS-1-i] = 1'b0;
      end
    end
  end

  assign shown = (32'(digit_count) > 32'(ptr_next));

  always_comb begin
    data_next = '0;
    case (mode)
      2'd0: data_next = shown ? (hex_seg(nib) | {7'b0, dp}) : 8'h00;
      2'd1: data_next = open_seg(ptr_next);
      2'd2: data_next = close_seg(ptr_next);
      default: data_next = raw | {7'b0, dp};
    endcase
  end

`ifdef SEG_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt, blink_cnt_next;
  logic          hidden, hidden_next;

  // The phase flips on the frame_start that begins frame BLINK_FRAMES+1, so digit 0
  // of that frame already sees the new phase.
  always_comb begin
    blink_cnt_next = blink_cnt;
    hidden_next    = hidden;
    if (!blink_en) begin
      blink_cnt_next = '0;
      hidden_next    = 1'b0;
    end else if (tick_now && (ptr_next == '0)) begin
      if (blink_cnt == BW'(BLINK_FRAMES)) begin
        blink_cnt_next = BW'(1);
        hidden_next    = !hidden;
      end else begin
        blink_cnt_next = blink_cnt + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      hidden    <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_next;
      hidden    <= hidden_next;
    end
  end

  assign blank = blink_en && hidden_next;
`else
  logic blink_unused;
  assign blink_unused = blink_en;
  assign blank        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= AW'(DIGITS - 1);
      seg_data    <= '0;
      seg_pos     <= '1;
      scan_tick   <= 1'b0;
      frame_start <= 1'b0;
    end else if (tick_now) begin
      ptr         <= ptr_next;
      seg_pos     <= enable ? pos_next : '1;
      seg_data    <= (enable && !blank) ? data_next : 8'h00;
      scan_tick   <= 1'b1;
      frame_start <= (ptr_next == '0);
    end else begin
      scan_tick   <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: expectations are queued as inputs are set and
// compared on every scan step; hold, tick period, reset and blink behaviour are also checked.
module tb_seg_scan_controller;

  localparam int DIGITS  = 6;
  localparam int CLK_DIV = 4;
  localparam int BF      = 2;
  localparam int W       = 1 + DIGITS + 8;

  logic                clk;
  logic                rst_n;
  logic                enable;
  logic [1:0]          mode;
  logic [4*DIGITS-1:0] digit_data;
  logic [3:0]          digit_count;
  logic [DIGITS-1:0]   dp_mask;
  logic [8*DIGITS-1:0] raw_seg;
  logic                blink_en;
  logic [7:0]          seg_data;
  logic [DIGITS-1:0]   seg_pos;
  logic                scan_tick;
  logic                frame_start;

  seg_scan_controller #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .digit_data(digit_data), .digit_count(digit_count), .dp_mask(dp_mask),
    .raw_seg(raw_seg), .blink_en(blink_en), .seg_data(seg_data), .seg_pos(seg_pos),
    .scan_tick(scan_tick), .frame_start(frame_start)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [W-1:0] exp_q[$];
  int  mptr;
  int  m_cnt;
  bit  m_hidden;
  logic [7:0] open_t[4];
  logic [7:0] close_t[5];
  logic [7:0] hex_t[16];

  initial begin
    open_t  = '{8'hFC, 8'hCE, 8'h9E, 8'hEC};
    close_t = '{8'h9C, 8'h1C, 8'hFC, 8'hB6, 8'h9E};
    hex_t   = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
  end

  task automatic model_reset();
    exp_q.delete();
    mptr     = DIGITS - 1;
    m_cnt    = 0;
    m_hidden = 0;
  endtask

  task automatic push_steps(input int n);
    logic [7:0]        d;
    logic [DIGITS-1:0] p;
    bit                blank;
    for (int k = 0; k < n; k++) begin
      mptr  = (mptr + 1) % DIGITS;
      blank = 0;
`ifdef SEG_BLINK_EN
      if (!blink_en) begin
        m_cnt    = 0;
        m_hidden = 0;
      end else if (mptr == 0) begin
        if (m_cnt == BF) begin
          m_cnt    = 1;
          m_hidden = !m_hidden;
        end else begin
          m_cnt++;
        end
      end
      blank = blink_en && m_hidden;
`endif
      case (mode)
        2'd0: d = (mptr < int'(digit_count)) ? (hex_t[digit_data[4*mptr +: 4]] | {7'b0, dp_mask[mptr]}) : 8'h00;
        2'd1: d = (mptr < 4) ? open_t[mptr] : 8'h00;
        2'd2: d = (mptr < 5) ? close_t[mptr] : 8'h00;
        default: d = raw_seg[8*mptr +: 8] | {7'b0, dp_mask[mptr]};
      endcase
      p = '1;
      p[DIGITS-1-mptr] = 1'b0;
      if (!enable) begin
        d = 8'h00;
        p = '1;
      end else if (blank) begin
        d = 8'h00;
      end
      exp_q.push_back({(mptr == 0), p, d});
    end
  endtask

  task automatic wait_drain(input int n);
    int guard = 0;
    while (exp_q.size() != 0 && guard < (n + 4) * CLK_DIV) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      check_val("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic run_steps(input int n);
    push_steps(n);
    wait_drain(n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_seg_data"}, seg_data, 8'h00);
    check_val({tag, "_seg_pos"}, seg_pos, {DIGITS{1'b1}});
    check_val({tag, "_scan_tick"}, scan_tick, 0);
    check_val({tag, "_frame_start"}, frame_start, 0);
  endtask

  task automatic release_and_time(input string tag);
    int c = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!scan_tick && c < 20);
    check_val(tag, c, CLK_DIV);
  endtask

  // Scoreboard monitor: compares each scan step, checks hold between steps and tick spacing
  logic [W-1:0]      e;
  logic [DIGITS+7:0] last_out;
  int                gap;
  bit                gap_valid;

  always @(negedge clk) begin
    if (!rst_n) begin
      gap_valid = 0;
      gap       = 0;
    end else begin
      gap++;
      if (scan_tick) begin
        if (gap_valid) check_val("tick_period", gap, CLK_DIV);
        if (exp_q.size() == 0) begin
          check_val("unexpected_tick", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_val("step_out", {frame_start, seg_pos, seg_data}, e);
        end
        last_out  = {seg_pos, seg_data};
        gap_valid = 1;
        gap       = 0;
      end else if (gap_valid) begin
        check_val("hold", {seg_pos, seg_data}, last_out);
        check_val("frame_start_idle", frame_start, 0);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b1;
    mode        = 2'd0;
    digit_data  = 24'h543210;
    digit_count = 4'd3;
    dp_mask     = 6'b000010;
    raw_seg     = '0;
    blink_en    = 1'b0;
    #12;
    check_reset_outputs("reset");

    // Numeric frame right after reset, with first-tick latency
    model_reset();
    push_steps(DIGITS);
    release_and_time("first_tick_cycle");
    wait_drain(DIGITS);

    // CLOSE, then switch to OPEN mid-frame without restarting the pointer
    mode = 2'd2;
    run_steps(3);
    mode = 2'd1;
    run_steps(3);
    mode = 2'd2;
    run_steps(DIGITS);

    // Display off for two steps, then numeric resumes at the advanced index
    enable = 1'b0;
    run_steps(2);
    enable = 1'b1;
    mode   = 2'd0;
    run_steps(4);

    // Numeric with random data and digit counts, including counts beyond DIGITS
    for (int f = 0; f < 4; f++) begin
      digit_data  = 24'($urandom);
      dp_mask     = 6'($urandom_range(0, 63));
      digit_count = (f == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      run_steps(DIGITS);
    end

    // Raw segment mode
    mode = 2'd3;
    for (int f = 0; f < 2; f++) begin
      raw_seg = {16'($urandom), 32'($urandom)};
      dp_mask = 6'($urandom_range(0, 63));
      run_steps(DIGITS);
    end

    // Blinking over six frames, then back to steady display
    mode        = 2'd0;
    digit_count = 4'd8;
    digit_data  = 24'h89ABCD;
    blink_en    = 1'b1;
    run_steps(6 * DIGITS);
    blink_en = 1'b0;
    run_steps(DIGITS);

    // Asynchronous reset mid-frame, checked before any clock edge
    run_steps(3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    model_reset();
    mode = 2'd1;
    push_steps(DIGITS);
    release_and_time("first_tick_after_rst");
    wait_drain(DIGITS);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
